// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: default widths,
// FSM state encoding, grant bookkeeping and the arbitration rule.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_D_BUSY  = 2'd2,
    ST_HALTED  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  // Data normally wins a tie; after a data grant the fetch side gets its turn
  // so neither requester can be starved.
  function automatic gnt_t pick_grant(input logic f_pend, input logic d_pend,
                                      input gnt_t last);
    gnt_t g;
    g = GNT_FETCH;
    if (f_pend && d_pend) begin
      g = (last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (d_pend) begin
      g = GNT_DATA;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Busy-cycle counter for one memory access. Cleared on grant, counts while the
// access is outstanding, and flags the MAX_WAIT-th busy cycle as expired so the
// arbiter can give up on a memory that never answers.
module mem_arbiter_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt;

  // Count busy cycles; saturate on the last one so a stuck enable cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The current busy cycle is the MAX_WAIT-th one.
  assign expired = enable & (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// One access outstanding at a time, one-cycle turnaround after every ack,
// fair tie-break, busy timeout, read/write conflict detection and halt.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              stall,
  output logic              err
);

  arb_state_t state, state_nxt;
  gnt_t       last_gnt;
  logic       halt_pend;

  logic f_pend, d_pend, turnaround, busy, expired;
  logic gnt_f, gnt_d, d_conflict, done;

  assign f_pend     = if_req;
  assign d_pend     = d_re | d_we;
  assign turnaround = if_ack | d_ack;
  assign busy       = (state == ST_IF_BUSY) || (state == ST_D_BUSY);
  assign done       = busy & (mem_rdy | expired);

  mem_arbiter_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (gnt_f | gnt_d),
    .enable  (busy),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant decision; grants only from IDLE outside the ack cycle.
  always_comb begin
    state_nxt  = state;
    gnt_f      = 1'b0;
    gnt_d      = 1'b0;
    d_conflict = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hlt || halt_pend) begin
          state_nxt = ST_HALTED;
        end else if (!turnaround && (f_pend || d_pend)) begin
          if (pick_grant(f_pend, d_pend, last_gnt) == GNT_DATA) begin
            if (d_re && d_we) begin
              d_conflict = 1'b1;
            end else begin
              gnt_d     = 1'b1;
              state_nxt = ST_D_BUSY;
            end
          end else begin
            gnt_f     = 1'b1;
            state_nxt = ST_IF_BUSY;
          end
        end
      end
      ST_IF_BUSY, ST_D_BUSY: begin
        if (mem_rdy || expired) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Memory command: latch the winner's request and strobe mem_en for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_gnt  <= GNT_FETCH;
    end else begin
      mem_en <= gnt_f | gnt_d;
      if (gnt_f) begin
        mem_addr <= if_addr;
        mem_we   <= 1'b0;
        last_gnt <= GNT_FETCH;
      end
      if (gnt_d) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
        last_gnt  <= GNT_DATA;
      end
      if (d_conflict) begin
        last_gnt <= GNT_DATA;
      end
    end
  end

  // Completion: one-cycle acks, captured read data (zero on timeout or conflict).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (d_conflict) begin
        d_ack   <= 1'b1;
        d_rdata <= '0;
      end
      if (done) begin
        if (state == ST_IF_BUSY) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdy ? mem_rdata : '0;
        end else begin
          d_ack <= 1'b1;
          if (!mem_we || !mem_rdy) begin
            d_rdata <= mem_rdy ? mem_rdata : '0;
          end
        end
      end
    end
  end

  // Sticky error and deferred halt request seen while an access is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      if (d_conflict || (done && !mem_rdy)) begin
        err <= 1'b1;
      end
      if (busy && hlt) begin
        halt_pend <= 1'b1;
      end
    end
  end

  // Pipeline freeze while any request is unanswered, and permanently once halted.
  always_comb begin
    stall = (f_pend & ~if_ack) | (d_pend & ~d_ack) | (state == ST_HALTED);
  end

endmodule
